// File: rtl/stopwatch_button_ctrl.sv
// Stopwatch input controller: synchronise and debounce the buttons, detect presses, run the run/pause/clear FSM.
// Optional lap/display-hold logic is built only when the LAP_HOLD_EN macro is defined.

module stopwatch_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_CNT_W        = 20
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync_p0;
  logic                sync_p1;
  logic [DB_CNT_W-1:0] db_cnt;
  logic                level_p2;
  logic                level_p3;
  logic                press_p3;

  // Stage p0/p1: two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      db_cnt   <= '0;
      level_p2 <= 1'b0;
    end else if (sync_p1 == level_p2) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      db_cnt   <= '0;
      level_p2 <= sync_p1;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Stage p3: registered rising-edge pulse of the debounced level.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      level_p3 <= 1'b0;
      press_p3 <= 1'b0;
    end else begin
      level_p3 <= level_p2;
      press_p3 <= level_p2 & ~level_p3;
    end
  end

  assign press = press_p3;

endmodule

module stopwatch_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_CNT_W        = 20
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       run,
  output logic       clear,
  output logic       display_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    BAD     = 2'b11
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   clear_q;
  logic   clear_d;
  logic   start_press;
  logic   clear_press;

  stopwatch_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_CNT_W        (DB_CNT_W)
  ) u_db_start (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .btn_raw      (btn_start_stop),
    .press        (start_press)
  );

  stopwatch_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_CNT_W        (DB_CNT_W)
  ) u_db_clear (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .btn_raw      (btn_clear),
    .press        (clear_press)
  );

  // Stage p4: FSM state and registered clear pulse.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_q <= IDLE;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
    end
  end

  // Clear takes priority over start/stop except in RUNNING, where clear is ignored.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_press) begin
          clear_d = 1'b1;
        end else if (start_press) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        if (start_press) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (clear_press) begin
          clear_d = 1'b1;
          state_d = IDLE;
        end else if (start_press) begin
          state_d = RUNNING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign run   = (state_q == RUNNING);
  assign clear = clear_q;
  assign state = state_q;

`ifdef LAP_HOLD_EN
  logic lap_press;
  logic hold_q;
  logic hold_d;

  stopwatch_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_CNT_W        (DB_CNT_W)
  ) u_db_lap (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .btn_raw      (btn_lap),
    .press        (lap_press)
  );

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // An accepted clear always releases the frozen lap value.
  always_comb begin
    hold_d = hold_q;
    if (clear_d) begin
      hold_d = 1'b0;
    end else if (lap_press && (state_q == RUNNING || state_q == PAUSED)) begin
      hold_d = ~hold_q;
    end
  end

  assign display_hold = hold_q;
`else
  logic lap_unused;
  assign lap_unused   = btn_lap;
  assign display_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// Directed bench for stopwatch_button_ctrl with DEBOUNCE_CYCLES=4 (raw rise to state change = 8 edges).
module tb_stopwatch_button_ctrl;

`ifdef LAP_HOLD_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic       clock_100Mhz = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic       run;
  logic       clear;
  logic       display_hold;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  stopwatch_button_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .DB_CNT_W        (3)
  ) dut (
    .clock_100Mhz   (clock_100Mhz),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .run            (run),
    .clear          (clear),
    .display_hold   (display_hold),
    .state          (state)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_100Mhz);
      #1;
    end
  endtask

  initial begin
    // Reset with all buttons pressed.
    btn_start_stop = 1'b1; btn_clear = 1'b1; btn_lap = 1'b1; reset = 1'b1;
    step(1);
    check_val("rst_run", run, 0);
    check_val("rst_clear", clear, 0);
    check_val("rst_hold", display_hold, 0);
    check_val("rst_state", state, 2'b00);
    btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0; reset = 1'b0;
    step(10);
    check_val("post_rst_state", state, 2'b00);

    // Short glitch is rejected.
    btn_start_stop = 1'b1; step(3); btn_start_stop = 1'b0; step(10);
    check_val("glitch_state", state, 2'b00);

    // Clean press: exactly 8 edges to RUNNING, one transition only.
    btn_start_stop = 1'b1;
    step(7);
    check_val("lat7_state", state, 2'b00);
    step(1);
    check_val("lat8_state", state, 2'b01);
    check_val("lat8_run", run, 1);
    step(12);
    check_val("held_state", state, 2'b01);
    btn_start_stop = 1'b0; step(10);
    check_val("release_state", state, 2'b01);

    // RUNNING -> PAUSED, then clear -> IDLE with one pulse.
    btn_start_stop = 1'b1; step(8);
    check_val("pause_state", state, 2'b10);
    check_val("pause_run", run, 0);
    btn_start_stop = 1'b0; step(10);
    btn_clear = 1'b1; step(7);
    check_val("clr7_clear", clear, 0);
    check_val("clr7_state", state, 2'b10);
    step(1);
    check_val("clr8_clear", clear, 1);
    check_val("clr8_state", state, 2'b00);
    step(1);
    check_val("clr9_clear", clear, 0);
    btn_clear = 1'b0; step(10);

    // Clear is ignored while RUNNING.
    btn_start_stop = 1'b1; step(8);
    check_val("run2_state", state, 2'b01);
    btn_start_stop = 1'b0; step(10);
    btn_clear = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_val("run_clr_pulse", clear, 0);
    end
    check_val("run_clr_run", run, 1);
    check_val("run_clr_state", state, 2'b01);
    btn_clear = 1'b0; step(10);

    // PAUSED with simultaneous start and clear: clear wins.
    btn_start_stop = 1'b1; step(8);
    check_val("pause2_state", state, 2'b10);
    btn_start_stop = 1'b0; step(10);
    btn_start_stop = 1'b1; btn_clear = 1'b1; step(8);
    check_val("sim_clear", clear, 1);
    check_val("sim_state", state, 2'b00);
    check_val("sim_run", run, 0);
    step(1);
    check_val("sim_clear_off", clear, 0);
    check_val("sim_state2", state, 2'b00);
    btn_start_stop = 1'b0; btn_clear = 1'b0; step(10);
    check_val("sim_state3", state, 2'b00);

    // Reset mid-debounce discards the pending press.
    btn_start_stop = 1'b1; step(4);
    btn_start_stop = 1'b0; reset = 1'b1; step(1);
    reset = 1'b0; step(10);
    check_val("rst_mid_state", state, 2'b00);
    check_val("rst_mid_run", run, 0);

    // Lap hold toggling in RUNNING and PAUSED; clear releases it.
    btn_start_stop = 1'b1; step(8);
    check_val("lap_run_state", state, 2'b01);
    btn_start_stop = 1'b0; step(10);
    btn_lap = 1'b1; step(8);
    check_val("lap1_hold", display_hold, LAP ? 1 : 0);
    btn_lap = 1'b0; step(10);
    btn_lap = 1'b1; step(8);
    check_val("lap2_hold", display_hold, 0);
    btn_lap = 1'b0; step(10);
    btn_start_stop = 1'b1; step(8);
    check_val("lap_pause_state", state, 2'b10);
    btn_start_stop = 1'b0; step(10);
    btn_lap = 1'b1; step(8);
    check_val("lap3_hold", display_hold, LAP ? 1 : 0);
    btn_lap = 1'b0; step(10);
    btn_clear = 1'b1; step(8);
    check_val("lap_clr_clear", clear, 1);
    check_val("lap_clr_hold", display_hold, 0);
    check_val("lap_clr_state", state, 2'b00);
    btn_clear = 1'b0; step(10);
    btn_lap = 1'b1; step(8);
    check_val("lap_idle_hold", display_hold, 0);
    btn_lap = 1'b0; step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
